// File: rtl/firebird7_in_gate1_tessent_pkg.sv
// Shared types and helpers for the firebird7 in_gate1 IJTAG mux controller.
package firebird7_in_gate1_tessent_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRAIN = 2'd2
  } mux_ctrl_state_e;

  // Scan segment length: one select-request bit on top of the data bits.
  function automatic int mux_ctrl_sr_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_shift.sv
// Capture/shift register of the TDR scan segment (LSB scans out first).
module firebird7_in_gate1_tessent_tdr_shift #(
  parameter int SR_W = 20
) (
  input  logic            ijtag_tck,
  input  logic            ijtag_reset,
  input  logic            i_sel,
  input  logic            i_ce,
  input  logic            i_se,
  input  logic            i_si,
  input  logic [SR_W-1:0] i_capture,
  output logic [SR_W-1:0] o_sr
);

  logic [SR_W-1:0] r_sr;

  // Capture wins over shift; register holds whenever the segment is not selected.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset)
      r_sr <= '0;
    else if (i_sel && i_ce)
      r_sr <= i_capture;
    else if (i_sel && i_se)
      r_sr <= {i_si, r_sr[SR_W-1:1]};
  end

  assign o_sr = r_sr;

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// IJTAG TDR sequencing the select/data of one ijtag/functional data mux with
// break-before-make ordering: select and new data never change on the same edge.
module firebird7_in_gate1_tessent_data_mux_ctrl
  import firebird7_in_gate1_tessent_pkg::*;
#(
  parameter int               WIDTH      = 19,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             ijtag_sel,
  input  logic             ijtag_ce,
  input  logic             ijtag_se,
  input  logic             ijtag_ue,
  input  logic             ijtag_si,
  output logic             ijtag_so,
  input  logic [WIDTH-1:0] functional_data_in,
  output logic             ijtag_select,
  output logic [WIDTH-1:0] ijtag_data_in,
  output logic             switch_busy
);

  localparam int MUX_CTRL_SR_W = mux_ctrl_sr_w(WIDTH);

  logic [MUX_CTRL_SR_W-1:0] w_sr;
  logic                     w_upd;

  mux_ctrl_state_e  r_state, w_state_nxt;
  logic             r_select, w_select_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [WIDTH-1:0] r_pend, w_pend_nxt;
  logic             r_busy;

  firebird7_in_gate1_tessent_tdr_shift #(
    .SR_W (MUX_CTRL_SR_W)
  ) u_shift (
    .ijtag_tck   (ijtag_tck),
    .ijtag_reset (ijtag_reset),
    .i_sel       (ijtag_sel),
    .i_ce        (ijtag_ce),
    .i_se        (ijtag_se),
    .i_si        (ijtag_si),
    .i_capture   ({r_select, functional_data_in}),
    .o_sr        (w_sr)
  );

  // Update only counts when it is the winning operation and no sequence is in flight.
  assign w_upd = ijtag_sel && ijtag_ue && !ijtag_ce && !ijtag_se && (r_state == IDLE);

  // Next-state/output decode. Exit parks the new data in r_pend so that shifting
  // during DRAIN cannot corrupt what lands on the mux one edge later.
  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_data_nxt   = r_data;
    w_pend_nxt   = r_pend;
    case (r_state)
      IDLE: begin
        if (w_upd) begin
          if (w_sr[WIDTH]) begin
            w_data_nxt = w_sr[WIDTH-1:0];
            if (!r_select) w_state_nxt = ARM;
          end else begin
            w_select_nxt = 1'b0;
            w_pend_nxt   = w_sr[WIDTH-1:0];
            w_state_nxt  = DRAIN;
          end
        end
      end
      ARM: begin
        w_select_nxt = 1'b1;
        w_state_nxt  = IDLE;
      end
      DRAIN: begin
        w_data_nxt  = r_pend;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and mux-facing output registers; busy is registered alongside the state.
  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_state  <= IDLE;
      r_select <= 1'b0;
      r_data   <= RESET_DATA;
      r_pend   <= RESET_DATA;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_select <= w_select_nxt;
      r_data   <= w_data_nxt;
      r_pend   <= w_pend_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

  assign ijtag_so      = w_sr[0];
  assign ijtag_select  = r_select;
  assign ijtag_data_in = r_data;
  assign switch_busy   = r_busy;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Directed self-checking bench for the IJTAG mux controller TDR.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

  localparam int W = 19;

  logic         tck = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b1, ce = 1'b0, se = 1'b0, ue = 1'b0, si = 1'b0;
  logic         so, select, busy;
  logic [W-1:0] fdata = '0;
  logic [W-1:0] data;
  logic [W:0]   got;

  int n_tests = 0;
  int n_fail  = 0;

  firebird7_in_gate1_tessent_data_mux_ctrl #(.WIDTH(W), .RESET_DATA('0)) dut (
    .ijtag_tck          (tck),
    .ijtag_reset        (rst),
    .ijtag_sel          (sel),
    .ijtag_ce           (ce),
    .ijtag_se           (se),
    .ijtag_ue           (ue),
    .ijtag_si           (si),
    .ijtag_so           (so),
    .functional_data_in (fdata),
    .ijtag_select       (select),
    .ijtag_data_in      (data),
    .switch_busy        (busy)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Shift a full 20-bit segment value, LSB first.
  task automatic shift_word(input logic [W:0] v);
    for (int i = 0; i <= W; i++) begin
      @(negedge tck);
      se = 1'b1;
      si = v[i];
    end
    @(negedge tck);
    se = 1'b0;
    si = 1'b0;
  endtask

  // Pulse ue over one edge (edge N); returns at the negedge after N.
  task automatic upd;
    @(negedge tck);
    ue = 1'b1;
    @(negedge tck);
    ue = 1'b0;
  endtask

  // Capture then shift out 20 bits observed on so.
  task automatic capture_and_read(output logic [W:0] v);
    @(negedge tck);
    ce = 1'b1;
    @(negedge tck);
    ce = 1'b0;
    se = 1'b1;
    for (int i = 0; i <= W; i++) begin
      v[i] = so;
      @(negedge tck);
    end
    se = 1'b0;
  endtask

  initial begin
    // Reset held from time 0
    #12;
    chk("rst_select", 32'(select), 32'h0);
    chk("rst_data",   32'(data),   32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_so",     32'(so),     32'h0);
    @(negedge tck);
    rst = 1'b0;

    // Enter ijtag mode
    shift_word({1'b1, 19'h5A5A5});
    upd();
    chk("enter_N_data",   32'(data),   32'h5A5A5);
    chk("enter_N_select", 32'(select), 32'h0);
    chk("enter_N_busy",   32'(busy),   32'h1);
    @(negedge tck);
    chk("enter_N1_select", 32'(select), 32'h1);
    chk("enter_N1_busy",   32'(busy),   32'h0);

    // Live rewrite
    shift_word({1'b1, 19'h00001});
    upd();
    chk("live_data",   32'(data),   32'h00001);
    chk("live_select", 32'(select), 32'h1);
    chk("live_busy",   32'(busy),   32'h0);

    // Exit
    shift_word({1'b0, 19'h7FFFF});
    upd();
    chk("exit_N_select", 32'(select), 32'h0);
    chk("exit_N_data",   32'(data),   32'h00001);
    chk("exit_N_busy",   32'(busy),   32'h1);
    @(negedge tck);
    chk("exit_N1_data", 32'(data), 32'h7FFFF);
    chk("exit_N1_busy", 32'(busy), 32'h0);

    // Capture with select=1
    shift_word({1'b1, 19'h5A5A5});
    upd();
    @(negedge tck);
    fdata = 19'h12345;
    capture_and_read(got);
    chk("capture_so", 32'(got), 32'h92345);

    // Update held over N and N+1 while DRAIN is busy: second one dropped
    shift_word({1'b0, 19'h11111});
    @(negedge tck);
    ue = 1'b1;
    @(negedge tck);
    chk("coll_N_busy", 32'(busy), 32'h1);
    @(negedge tck);
    ue = 1'b0;
    chk("coll_N1_busy",   32'(busy),   32'h0);
    chk("coll_N1_select", 32'(select), 32'h0);
    chk("coll_N1_data",   32'(data),   32'h11111);

    // ce+se+ue together: capture only
    shift_word({1'b1, 19'h22222});
    fdata = 19'h3C3C3;
    @(negedge tck);
    ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b1;
    @(negedge tck);
    ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    chk("cseu_busy", 32'(busy), 32'h0);
    @(negedge tck);
    chk("cseu_select", 32'(select), 32'h0);
    chk("cseu_data",   32'(data),   32'h11111);
    se = 1'b1;
    for (int i = 0; i <= W; i++) begin
      got[i] = so;
      @(negedge tck);
    end
    se = 1'b0;
    chk("cseu_so", 32'(got), 32'h3C3C3);

    // Segment deselected: ue and se ignored, shift_reg holds
    shift_word({1'b1, 19'h44444});
    @(negedge tck);
    sel = 1'b0; ue = 1'b1; se = 1'b1; si = 1'b0;
    @(negedge tck);
    @(negedge tck);
    ue = 1'b0; se = 1'b0;
    chk("nosel_busy",   32'(busy),   32'h0);
    chk("nosel_select", 32'(select), 32'h0);
    chk("nosel_data",   32'(data),   32'h11111);
    sel = 1'b1;
    upd();
    chk("nosel_held_data", 32'(data), 32'h44444);
    chk("nosel_held_busy", 32'(busy), 32'h1);
    @(negedge tck);
    chk("nosel_held_select", 32'(select), 32'h1);

    // Reset in the middle of ARM
    shift_word({1'b0, 19'h0});
    upd();
    @(negedge tck);
    shift_word({1'b1, 19'h55555});
    upd();
    chk("armrst_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("armrst_select", 32'(select), 32'h0);
    chk("armrst_data",   32'(data),   32'h0);
    chk("armrst_busy",   32'(busy),   32'h0);
    chk("armrst_so",     32'(so),     32'h0);
    @(negedge tck);
    rst = 1'b0;
    @(negedge tck);
    chk("armrst_after_select", 32'(select), 32'h0);
    chk("armrst_after_busy",   32'(busy),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
